// File: rtl/pivota_order_engine_if.sv
// pivota_order_engine_if
//   Groups the tick input stream and the order output stream of the
//   Pivota order engine.
//   master : tick source / order consumer (drives tick_*, operands, ord_ready)
//   slave  : the engine (drives tick_ready, ord_valid, ord_side, ord_qty, ord_seq)
interface pivota_order_engine_if #(
    parameter int DATA_W = 32,
    parameter int QTY_W  = 4,
    parameter int REP_W  = 4,
    parameter int SEQ_W  = 8
);
    logic              tick_valid;
    logic              tick_ready;
    logic [DATA_W-1:0] total;
    logic [DATA_W-1:0] threshold;
    logic [DATA_W-1:0] correction;
    logic [DATA_W-1:0] price;
    logic [QTY_W-1:0]  buy_qty;
    logic [QTY_W-1:0]  sell_qty;
    logic [REP_W-1:0]  repeat_cnt;

    logic              ord_valid;
    logic              ord_ready;
    logic [1:0]        ord_side;
    logic [QTY_W-1:0]  ord_qty;
    logic [SEQ_W-1:0]  ord_seq;

    modport master (
        output tick_valid, total, threshold, correction, price,
               buy_qty, sell_qty, repeat_cnt, ord_ready,
        input  tick_ready, ord_valid, ord_side, ord_qty, ord_seq
    );

    modport slave (
        input  tick_valid, total, threshold, correction, price,
               buy_qty, sell_qty, repeat_cnt, ord_ready,
        output tick_ready, ord_valid, ord_side, ord_qty, ord_seq
    );
endinterface

// File: rtl/pivota_order_engine.sv
// pivota_order_engine
//   Evaluates each accepted market tick against three rules (threshold buy,
//   correction sell, repeated unit buy) and streams the resulting orders out
//   of an internal FIFO over a valid/ready handshake.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : tick stream in, order stream out (slave modport)
//   fifo_level : current FIFO occupancy, 0..DEPTH
//   busy       : high whenever the FSM is not idle
module pivota_order_engine #(
    parameter int DATA_W = 32,
    parameter int QTY_W  = 4,
    parameter int DEPTH  = 16,
    parameter int REP_W  = 4,
    parameter int SEQ_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pivota_order_engine_if.slave   bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_EVAL_BUY  = 2'd1;
    localparam logic [1:0] ST_EVAL_SELL = 2'd2;
    localparam logic [1:0] ST_REPEAT    = 2'd3;

    localparam logic [1:0] SIDE_BUY  = 2'd1;
    localparam logic [1:0] SIDE_SELL = 2'd2;

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] total_q, total_d;
    logic [DATA_W-1:0] threshold_q, threshold_d;
    logic [DATA_W-1:0] correction_q, correction_d;
    logic [DATA_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]  buy_qty_q, buy_qty_d;
    logic [QTY_W-1:0]  sell_qty_q, sell_qty_d;
    logic [REP_W-1:0]  repeat_cnt_q, repeat_cnt_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;

    logic [1:0]        side_mem [DEPTH];
    logic [QTY_W-1:0]  qty_mem  [DEPTH];
    logic [SEQ_W-1:0]  seq_mem  [DEPTH];

    logic              full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic [1:0]        push_side;
    logic [QTY_W-1:0]  push_qty;

    // Full is taken from the registered level, so a pop in the same cycle
    // never frees a slot for a push until the following cycle.
    assign full = (level_q == FULL_LVL);
    assign push = push_req && !full;
    assign pop  = bus.ord_valid && bus.ord_ready;

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        threshold_d  = threshold_q;
        correction_d = correction_q;
        price_d      = price_q;
        buy_qty_d    = buy_qty_q;
        sell_qty_d   = sell_qty_q;
        repeat_cnt_d = repeat_cnt_q;
        rep_d        = rep_q;
        push_req     = 1'b0;
        push_side    = SIDE_BUY;
        push_qty     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tick_valid) begin
                    total_d      = bus.total;
                    threshold_d  = bus.threshold;
                    correction_d = bus.correction;
                    price_d      = bus.price;
                    buy_qty_d    = bus.buy_qty;
                    sell_qty_d   = bus.sell_qty;
                    repeat_cnt_d = bus.repeat_cnt;
                    state_d      = ST_EVAL_BUY;
                end
            end
            ST_EVAL_BUY: begin
                if ((total_q > threshold_q) && (buy_qty_q != '0)) begin
                    push_req  = 1'b1;
                    push_side = SIDE_BUY;
                    push_qty  = buy_qty_q;
                end
                if (!push_req || !full) begin
                    state_d = ST_EVAL_SELL;
                end
            end
            ST_EVAL_SELL: begin
                if ((correction_q < price_q) && (sell_qty_q != '0)) begin
                    push_req  = 1'b1;
                    push_side = SIDE_SELL;
                    push_qty  = sell_qty_q;
                end
                if (!push_req || !full) begin
                    rep_d   = repeat_cnt_q;
                    state_d = ST_REPEAT;
                end
            end
            default: begin
                if (rep_q != '0) begin
                    push_req  = 1'b1;
                    push_side = SIDE_BUY;
                    push_qty  = QTY_W'(1);
                    if (!full) begin
                        rep_d = rep_q - 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        seq_d    = seq_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            seq_d    = seq_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            total_q      <= '0;
            threshold_q  <= '0;
            correction_q <= '0;
            price_q      <= '0;
            buy_qty_q    <= '0;
            sell_qty_q   <= '0;
            repeat_cnt_q <= '0;
            rep_q        <= '0;
            seq_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            threshold_q  <= threshold_d;
            correction_q <= correction_d;
            price_q      <= price_d;
            buy_qty_q    <= buy_qty_d;
            sell_qty_q   <= sell_qty_d;
            repeat_cnt_q <= repeat_cnt_d;
            rep_q        <= rep_d;
            seq_q        <= seq_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible while level_q says so.
    always_ff @(posedge clk) begin
        if (push) begin
            side_mem[wr_ptr_q] <= push_side;
            qty_mem[wr_ptr_q]  <= push_qty;
            seq_mem[wr_ptr_q]  <= seq_q;
        end
    end

    assign bus.tick_ready = (state_q == ST_IDLE) && rst_n;
    assign bus.ord_valid  = (level_q != '0);
    assign bus.ord_side   = bus.ord_valid ? side_mem[rd_ptr_q] : 2'd0;
    assign bus.ord_qty    = bus.ord_valid ? qty_mem[rd_ptr_q]  : '0;
    assign bus.ord_seq    = bus.ord_valid ? seq_mem[rd_ptr_q]  : '0;
    assign fifo_level     = level_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pivota_order_engine.sv
// tb_pivota_order_engine
//   Scoreboard bench: expected orders are queued when a tick is driven and
//   compared against every order the engine hands over.
module tb_pivota_order_engine;
    localparam int DATA_W = 32;
    localparam int QTY_W  = 4;
    localparam int DEPTH  = 4;
    localparam int REP_W  = 4;
    localparam int SEQ_W  = 8;

    localparam logic [1:0] SIDE_BUY  = 2'd1;
    localparam logic [1:0] SIDE_SELL = 2'd2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   busy;

    pivota_order_engine_if #(
        .DATA_W(DATA_W), .QTY_W(QTY_W), .REP_W(REP_W), .SEQ_W(SEQ_W)
    ) bus ();

    pivota_order_engine #(
        .DATA_W(DATA_W), .QTY_W(QTY_W), .DEPTH(DEPTH),
        .REP_W(REP_W), .SEQ_W(SEQ_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fifo_level(fifo_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned      n_tests = 0;
    int unsigned      n_fail  = 0;
    logic [SEQ_W-1:0] model_seq = '0;
    logic [63:0]      sb_q [$];
    logic [63:0]      last_head = '0;
    logic             last_stall = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_ord(input logic [1:0] s, input logic [QTY_W-1:0] q,
                                             input logic [SEQ_W-1:0] sq);
        return 64'({s, q, sq});
    endfunction

    // Order monitor: inputs change at posedge+1, so at negedge both the head
    // and ord_ready are the values the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_stall = 1'b0;
        end else begin
            if (last_stall && bus.ord_valid)
                check_eq("head_stable", pack_ord(bus.ord_side, bus.ord_qty, bus.ord_seq), last_head);
            if (!bus.ord_valid)
                check_eq("side_idle", 64'(bus.ord_side), 64'd0);
            if (bus.ord_valid && bus.ord_ready) begin
                if (sb_q.size() == 0)
                    check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
                else
                    check_eq("order", pack_ord(bus.ord_side, bus.ord_qty, bus.ord_seq), sb_q.pop_front());
            end
            last_stall = bus.ord_valid && !bus.ord_ready;
            last_head  = pack_ord(bus.ord_side, bus.ord_qty, bus.ord_seq);
        end
    end

    task automatic send_tick(input logic [DATA_W-1:0] t, input logic [DATA_W-1:0] thr,
                             input logic [DATA_W-1:0] corr, input logic [DATA_W-1:0] pr,
                             input logic [QTY_W-1:0] bq, input logic [QTY_W-1:0] sq,
                             input logic [REP_W-1:0] rep);
        int n = 0;
        while (!bus.tick_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("tick_ready_wait", 64'(bus.tick_ready), 64'd1);
        bus.total      = t;
        bus.threshold  = thr;
        bus.correction = corr;
        bus.price      = pr;
        bus.buy_qty    = bq;
        bus.sell_qty   = sq;
        bus.repeat_cnt = rep;
        bus.tick_valid = 1'b1;
        if (t > thr && bq != '0) begin
            sb_q.push_back(pack_ord(SIDE_BUY, bq, model_seq));
            model_seq++;
        end
        if (corr < pr && sq != '0) begin
            sb_q.push_back(pack_ord(SIDE_SELL, sq, model_seq));
            model_seq++;
        end
        for (int i = 0; i < int'(rep); i++) begin
            sb_q.push_back(pack_ord(SIDE_BUY, QTY_W'(1), model_seq));
            model_seq++;
        end
        @(posedge clk); #1;
        bus.tick_valid = 1'b0;
    endtask

    task automatic wait_idle(output int turn);
        turn = 0;
        do begin
            @(posedge clk); #1;
            turn++;
        end while (!bus.tick_ready && turn < 2000);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || fifo_level != '0) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain_sb", 64'(sb_q.size()), 64'd0);
        check_eq("drain_level", 64'(fifo_level), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int turn;
        int n;
        bus.tick_valid = 1'b0;
        bus.total      = '0;
        bus.threshold  = '0;
        bus.correction = '0;
        bus.price      = '0;
        bus.buy_qty    = '0;
        bus.sell_qty   = '0;
        bus.repeat_cnt = '0;
        bus.ord_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tick_ready", 64'(bus.tick_ready), 64'd0);
        check_eq("rst_ord_valid", 64'(bus.ord_valid), 64'd0);
        check_eq("rst_ord_side", 64'(bus.ord_side), 64'd0);
        check_eq("rst_ord_qty", 64'(bus.ord_qty), 64'd0);
        check_eq("rst_ord_seq", 64'(bus.ord_seq), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_tick_ready", 64'(bus.tick_ready), 64'd1);
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        // Baseline: threshold buy plus two unit buys, no sell.
        bus.ord_ready = 1'b1;
        send_tick(500, 450, 200, 100, 5, 3, 2);
        check_eq("base_busy", 64'(busy), 64'd1);
        wait_idle(turn);
        check_eq("base_turnaround", 64'(turn), 64'd5);
        wait_drain();

        // Equality on the buy rule, strict less on the sell rule.
        send_tick(450, 450, 99, 100, 7, 3, 0);
        wait_idle(turn);
        check_eq("eq_turnaround", 64'(turn), 64'd3);
        wait_drain();

        // Zero buy quantity suppresses the buy; equal correction/price suppresses the sell.
        send_tick(600, 100, 100, 100, 0, 3, 1);
        wait_idle(turn);
        check_eq("bq0_turnaround", 64'(turn), 64'd4);
        wait_drain();

        // Back-pressure: six unit buys into a four-deep FIFO.
        bus.ord_ready = 1'b0;
        send_tick(0, 1, 5, 5, 2, 2, 6);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_eq("bp_level_full", 64'(fifo_level), 64'd4);
        check_eq("bp_tick_ready", 64'(bus.tick_ready), 64'd0);
        check_eq("bp_busy", 64'(busy), 64'd1);
        bus.ord_ready = 1'b1;
        @(posedge clk); #1;
        bus.ord_ready = 1'b0;
        check_eq("bp_pop_no_push", 64'(fifo_level), 64'd3);
        @(posedge clk); #1;
        check_eq("bp_push_next", 64'(fifo_level), 64'd4);
        bus.ord_ready = 1'b1;
        wait_idle(turn);
        check_eq("bp_idle", 64'(bus.tick_ready), 64'd1);
        wait_drain();

        // Sequence wrap: 300 unit buys across 20 ticks.
        for (int k = 0; k < 20; k++) begin
            send_tick(0, 0, 0, 0, 1, 1, 15);
            wait_idle(turn);
            check_eq("wrap_turnaround", 64'(turn), 64'd18);
        end
        wait_drain();

        // Reset mid-REPEAT with three orders queued.
        bus.ord_ready = 1'b0;
        send_tick(0, 1, 5, 5, 0, 0, 10);
        n = 0;
        while (fifo_level != 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("mid_level", 64'(fifo_level), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus.ord_valid), 64'd0);
        check_eq("mid_rst_level", 64'(fifo_level), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_tick_ready", 64'(bus.tick_ready), 64'd0);
        sb_q.delete();
        model_seq = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_post_tick_ready", 64'(bus.tick_ready), 64'd1);
        bus.ord_ready = 1'b1;
        send_tick(10, 5, 0, 0, 9, 0, 0);
        wait_idle(turn);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
